// File: rtl/unpadding_stream_pkg.sv
// Shared definitions for the padding/unpadding stream pair: row-region
// state enum and the border / padded-frame geometry helpers.
package unpadding_stream_pkg;

    typedef enum logic [1:0] {
        TOP    = 2'd0,
        BODY   = 2'd1,
        BOTTOM = 2'd2
    } pad_state_t;

    function automatic int calc_pad(input int kernal_size);
        return (kernal_size - 1) / 2;
    endfunction

    function automatic int calc_padded_width(input int image_width, input int kernal_size);
        return image_width + kernal_size - 1;
    endfunction

    function automatic int calc_padded_height(input int image_height, input int kernal_size);
        return image_height + kernal_size - 1;
    endfunction

    // With no border there is no top region, so a frame starts in BODY.
    function automatic pad_state_t start_state(input int kernal_size);
        return (kernal_size > 1) ? TOP : BODY;
    endfunction

endpackage

// File: rtl/unpadding_stream.sv
// Strips the (kernalSize-1)/2 border from a padded row-major pixel stream.
// Optional framing check on in_last: define UNPADDING_FRAME_CHECK_EN.
module unpadding_stream
    import unpadding_stream_pkg::*;
#(
    parameter int imageWidth  = 3,
    parameter int imageHeight = 3,
    parameter int kernalSize  = 3,
    parameter int wordlength  = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [wordlength-1:0] in_data,
    input  logic                  in_valid,
    input  logic                  in_last,
    output logic                  in_ready,
    output logic [wordlength-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_last,
    output logic                  err
);

    localparam int P  = calc_pad(kernalSize);
    localparam int W  = calc_padded_width(imageWidth, kernalSize);
    localparam int H  = calc_padded_height(imageHeight, kernalSize);
    localparam int CW = $clog2(W + 1);
    localparam int RW = $clog2(H + 1);

    localparam logic [CW-1:0] COL_LAST   = CW'(W - 1);
    localparam logic [CW-1:0] COL_FIRST  = CW'(P);
    localparam logic [CW-1:0] COL_SPAN   = CW'(imageWidth);
    localparam logic [CW-1:0] COL_END    = CW'(P + imageWidth - 1);
    localparam logic [RW-1:0] ROW_LAST   = RW'(H - 1);
    localparam logic [RW-1:0] ROW_BODY   = RW'(P);
    localparam logic [RW-1:0] ROW_BOTTOM = RW'(P + imageHeight);
    localparam logic [RW-1:0] ROW_END    = RW'(P + imageHeight - 1);
    localparam pad_state_t    START      = start_state(kernalSize);

    pad_state_t    state, state_nxt;
    logic [CW-1:0] col, col_nxt, col_off;
    logic [RW-1:0] row, row_nxt;
    logic          in_fire, keep, interior, is_last;

    // Valid/ready: a beat transfers on a rising edge where valid && ready are
    // both high; valid never waits on ready, and an offered beat holds stable
    // until it transfers. The output stage accepts whenever it is empty or
    // being drained this cycle, and border pixels obey the same rule.
    assign in_ready = !out_valid || out_ready;
    assign in_fire  = in_valid && in_ready;

    // Wrapping subtraction: columns left of the border land far above COL_SPAN.
    assign col_off  = col - COL_FIRST;
    assign is_last  = (row == ROW_END) && (col == COL_END);
    assign interior = in_fire && keep && (state == BODY) && (col_off < COL_SPAN);

`ifdef UNPADDING_FRAME_CHECK_EN
    logic at_end;
    assign at_end = (row == ROW_LAST) && (col == COL_LAST);
    // A misplaced in_last ends the frame early and its pixel is discarded.
    assign keep   = !(in_last && !at_end);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err <= 1'b0;
        end else if (in_fire && (in_last != at_end)) begin
            err <= 1'b1;
        end
    end
`else
    logic unused_in_last;
    assign unused_in_last = in_last;
    assign keep           = 1'b1;
    assign err            = 1'b0;
`endif

    always_comb begin
        col_nxt   = col;
        row_nxt   = row;
        state_nxt = state;
        if (in_fire) begin
            if (col == COL_LAST) begin
                col_nxt = '0;
                row_nxt = (row == ROW_LAST) ? '0 : row + RW'(1);
            end else begin
                col_nxt = col + CW'(1);
            end
`ifdef UNPADDING_FRAME_CHECK_EN
            if (in_last) begin
                col_nxt = '0;
                row_nxt = '0;
            end
`endif
            if (row_nxt == '0) begin
                state_nxt = START;
            end else begin
                case (state)
                    TOP:     if (row_nxt == ROW_BODY)   state_nxt = BODY;
                    BODY:    if (row_nxt == ROW_BOTTOM) state_nxt = BOTTOM;
                    default: state_nxt = state;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            col   <= '0;
            row   <= '0;
            state <= START;
        end else begin
            col   <= col_nxt;
            row   <= row_nxt;
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_data  <= '0;
        end else if (in_ready) begin
            out_valid <= interior;
            out_last  <= interior && is_last;
            if (interior) begin
                out_data <= in_data;
            end
        end
    end

endmodule

// File: tb/tb_unpadding_stream.sv
// Self-checking bench for unpadding_stream (default geometry plus a
// kernalSize=1 instance); framing-check cases build with UNPADDING_FRAME_CHECK_EN.
`timescale 1ns/1ps
module tb_unpadding_stream;

    localparam int WL = 32;
    localparam int IW = 3;
    localparam int IH = 3;
    localparam int KS = 3;
    localparam int PP = (KS - 1) / 2;
    localparam int PW = IW + KS - 1;
    localparam int PH = IH + KS - 1;
    localparam int NPIX = PW * PH;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [WL-1:0] in_data = '0;
    logic          in_valid = 1'b0;
    logic          in_last = 1'b0;
    logic          in_ready;
    logic [WL-1:0] out_data;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic          out_last;
    logic          err;

    logic [WL-1:0] k1_in_data = '0;
    logic          k1_in_valid = 1'b0;
    logic          k1_in_last = 1'b0;
    logic          k1_in_ready;
    logic [WL-1:0] k1_out_data;
    logic          k1_out_valid;
    logic          k1_out_ready = 1'b1;
    logic          k1_out_last;
    logic          k1_err;

    unpadding_stream #(
        .imageWidth(IW), .imageHeight(IH), .kernalSize(KS), .wordlength(WL)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .in_data(in_data), .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_last(out_last), .err(err)
    );

    unpadding_stream #(
        .imageWidth(2), .imageHeight(2), .kernalSize(1), .wordlength(WL)
    ) dut_k1 (
        .clk(clk), .rst_n(rst_n),
        .in_data(k1_in_data), .in_valid(k1_in_valid), .in_last(k1_in_last), .in_ready(k1_in_ready),
        .out_data(k1_out_data), .out_valid(k1_out_valid), .out_ready(k1_out_ready),
        .out_last(k1_out_last), .err(k1_err)
    );

    int n_total = 0;
    int n_bad   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // ---------------- reference model + scoreboard ----------------
    logic [WL-1:0] frame_px [NPIX];
    logic [WL:0]   exp_q[$];
    logic [WL:0]   mon_e;
    logic          sb_en = 1'b0;
    int            last_cnt = 0;
    logic          prev_stall = 1'b0;
    logic [WL-1:0] held_data;
    logic          held_last;

    // Interior = padded coordinates inside the border on both axes.
    task automatic push_expected(input int max_items);
        int pushed = 0;
        for (int r = 0; r < PH; r++) begin
            for (int c = 0; c < PW; c++) begin
                if (r >= PP && r < PP + IH && c >= PP && c < PP + IW && pushed < max_items) begin
                    exp_q.push_back({(r == PP + IH - 1) && (c == PP + IW - 1), frame_px[r * PW + c]});
                    pushed++;
                end
            end
        end
    endtask

    always @(negedge clk) begin
        if (sb_en && rst_n) begin
            if (prev_stall) begin
                check("hold_valid", out_valid, 1'b1);
                check("hold_data", out_data, held_data);
                check("hold_last", out_last, held_last);
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    n_total++;
                    n_bad++;
                    $display("FAIL unexpected_out: got %0h expected nothing (t=%0t)", out_data, $time);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("out_data", out_data, mon_e[WL-1:0]);
                    check("out_last", out_last, mon_e[WL]);
                end
                if (out_last) last_cnt++;
            end
            prev_stall = out_valid && !out_ready;
            held_data  = out_data;
            held_last  = out_last;
        end else begin
            prev_stall = 1'b0;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic send_pixel(input logic [WL-1:0] d, input logic last);
        int waited = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            waited++;
            if (waited >= 200) break;
        end
        if (waited >= 200) begin
            n_total++;
            n_bad++;
            $display("FAIL in_ready_timeout: got 0 expected 1 (data %0h)", d);
            #1;
        end else begin
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic send_frame(input int count, input int max_gap);
        for (int i = 0; i < count; i++) begin
            repeat ($urandom_range(0, max_gap)) begin
                @(posedge clk);
                #1;
            end
            send_pixel(frame_px[i], i == NPIX - 1);
        end
    endtask

    task automatic wait_drain();
        int guard = 0;
        while ((exp_q.size() != 0 || out_valid) && guard < 200) begin
            @(posedge clk);
            #1;
            guard++;
        end
        check("drain_done", guard < 200, 1'b1);
    endtask

    task automatic ramp_frame();
        for (int i = 0; i < NPIX; i++) frame_px[i] = WL'(i);
    endtask

    // ---------------- vectors ----------------
    typedef struct {
        logic [WL-1:0] din;
        logic          last;
        logic          exp_ov;
        logic [WL-1:0] exp_od;
        logic          exp_ol;
    } vec_t;

    vec_t vecs [NPIX];
    int   interior_ids [9] = '{6, 7, 8, 11, 12, 13, 16, 17, 18};
    logic rnd_done;

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin : main
        for (int i = 0; i < NPIX; i++) begin
            vecs[i].din    = WL'(i);
            vecs[i].last   = (i == NPIX - 1);
            vecs[i].exp_ov = 1'b0;
            vecs[i].exp_od = WL'(i);
            vecs[i].exp_ol = (i == 18);
            foreach (interior_ids[j]) if (interior_ids[j] == i) vecs[i].exp_ov = 1'b1;
        end

        apply_reset();
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out_last", out_last, 1'b0);
        check("rst_out_data", out_data, '0);
        check("rst_err", err, 1'b0);
        check("rst_in_ready", in_ready, 1'b1);

        // Back-to-back ramp frame, one output per cycle after acceptance.
        for (int i = 0; i < NPIX; i++) begin
            in_valid = 1'b1;
            in_data  = vecs[i].din;
            in_last  = vecs[i].last;
            check("tbl_in_ready", in_ready, 1'b1);
            @(posedge clk);
            #1;
            check("tbl_out_valid", out_valid, vecs[i].exp_ov);
            if (vecs[i].exp_ov) begin
                check("tbl_out_data", out_data, vecs[i].exp_od);
                check("tbl_out_last", out_last, vecs[i].exp_ol);
            end
        end
        in_valid = 1'b0;
        in_last  = 1'b0;

        // Downstream stall on pixel 12.
        sb_en = 1'b1;
        ramp_frame();
        push_expected(9);
        fork
            send_frame(NPIX, 0);
            begin : stall_ctl
                int guard = 0;
                while (!(out_valid && out_data == 12) && guard < 100) begin
                    @(posedge clk);
                    #1;
                    guard++;
                end
                check("stall_found_12", guard < 100, 1'b1);
                out_ready = 1'b0;
                repeat (3) begin
                    @(negedge clk);
                    check("stall_data", out_data, 12);
                    check("stall_valid", out_valid, 1'b1);
                    check("stall_in_ready", in_ready, 1'b0);
                end
                @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        wait_drain();

        // Reset in the middle of a frame.
        ramp_frame();
        push_expected(5);
        for (int i = 0; i <= 12; i++) send_pixel(frame_px[i], 1'b0);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        check("midrst_out_valid", out_valid, 1'b0);
        check("midrst_q_empty", exp_q.size(), 0);
        push_expected(9);
        send_frame(NPIX, 0);
        wait_drain();

        // Two random frames, random gaps, random downstream ready.
        last_cnt = 0;
        rnd_done = 1'b0;
        fork
            begin
                for (int f = 0; f < 2; f++) begin
                    for (int i = 0; i < NPIX; i++) frame_px[i] = $urandom;
                    push_expected(9);
                    send_frame(NPIX, 2);
                end
                rnd_done = 1'b1;
            end
            begin
                while (!rnd_done) begin
                    @(posedge clk);
                    #1;
                    out_ready = ($urandom_range(0, 3) != 0);
                end
                out_ready = 1'b1;
            end
        join
        wait_drain();
        check("rnd_last_pulses", last_cnt, 2);

`ifdef UNPADDING_FRAME_CHECK_EN
        // Early in_last at index 10, then a clean frame.
        check("pre_err", err, 1'b0);
        ramp_frame();
        push_expected(3);
        for (int i = 0; i <= 10; i++) send_pixel(frame_px[i], i == 10);
        check("err_set", err, 1'b1);
        push_expected(9);
        send_frame(NPIX, 0);
        wait_drain();
        check("err_sticky", err, 1'b1);
`else
        check("err_tied_low", err, 1'b0);
`endif

        // kernalSize=1: every pixel is interior.
        sb_en = 1'b0;
        for (int i = 0; i < 4; i++) begin
            k1_in_valid = 1'b1;
            k1_in_data  = WL'(i);
            check("k1_in_ready", k1_in_ready, 1'b1);
            @(posedge clk);
            #1;
            check("k1_out_valid", k1_out_valid, 1'b1);
            check("k1_out_data", k1_out_data, WL'(i));
            check("k1_out_last", k1_out_last, i == 3);
        end
        k1_in_valid = 1'b0;
        @(posedge clk);
        #1;
        check("k1_idle", k1_out_valid, 1'b0);
        check("k1_err", k1_err, 1'b0);

        check("final_q_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/unpadding_stream.md
UNPADDING_STREAM -- requirements
Module: unpadding_stream

Interface
REQ-001 Parameter imageWidth, default 3, SHALL set interior (unpadded) pixels per row.
REQ-002 Parameter imageHeight, default 3, SHALL set interior rows per frame.
REQ-003 Parameter kernalSize, default 3, SHALL be odd and >=1; border width P=(kernalSize-1)/2 on each side.
REQ-004 Parameter wordlength, default 32, SHALL set bits per pixel.
REQ-005 Ports (name, direction, width, meaning) SHALL be:
- clk, in, 1, sole clock, rising edge.
- rst_n, in, 1, synchronous active-low reset.
- in_data, in, wordlength, padded-frame pixel.
- in_valid, in, 1, in_data valid.
- in_last, in, 1, marks last padded pixel of a frame.
- in_ready, out, 1, block accepts a pixel.
- out_data, out, wordlength, interior pixel.
- out_valid, out, 1, out_data valid.
- out_ready, in, 1, downstream accepts.
- out_last, out, 1, last interior pixel of a frame.
- err, out, 1, sticky framing error.

Function
REQ-006 Input frame SHALL be W=imageWidth+kernalSize-1 by H=imageHeight+kernalSize-1 pixels, row-major, row 0 / column 0 first.
REQ-007 Column counter col (0..W-1) and row counter row (0..H-1) SHALL advance only on input handshake (in_valid && in_ready); col wraps to 0 and increments row; row wraps to 0 after (H-1,W-1).
REQ-008 FSM SHALL have states TOP (row<P), BODY (P<=row<P+imageHeight), BOTTOM (row>=P+imageHeight); transitions occur on the handshake that moves row across a boundary; BOTTOM->TOP on frame wrap; kernalSize=1 SHALL stay in BODY.
REQ-009 A pixel SHALL be interior iff state is BODY and P<=col<P+imageWidth; interior pixels forward, border pixels are consumed and dropped.
REQ-010 Output SHALL be a single registered stage: interior pixel accepted in cycle N appears on out_data/out_valid in cycle N+1.
REQ-011 in_ready SHALL equal !out_valid || out_ready (combinational); border pixels obey the same ready.
REQ-012 out_valid/out_data/out_last SHALL hold stable while out_valid && !out_ready.
REQ-013 Simultaneous output drain and new interior input SHALL load the new pixel with no bubble; full throughput one pixel/cycle.
REQ-014 out_last SHALL be 1 only with the pixel at (P+imageHeight-1, P+imageWidth-1).

Reset
REQ-015 When rst_n=0 at a clk edge: row=0, col=0, state=TOP (BODY if kernalSize=1), out_valid=0, out_last=0, out_data=0, err=0; in-flight frame discarded.
REQ-016 in_ready SHALL be 1 in the first cycle after reset.

Configuration
REQ-017 Macro UNPADDING_FRAME_CHECK_EN defined: a handshake with in_last=1 at position other than (H-1,W-1), or in_last=0 at (H-1,W-1), SHALL set err=1 (sticky until reset); on in_last=1 counters resync to (0,0) and the current pixel is dropped if misplaced.
REQ-018 Macro undefined: in_last SHALL be ignored, err tied to 0, counters free-run per REQ-007.

Structure
REQ-019 Shared package SHALL hold the FSM state enum (TOP, BODY, BOTTOM) and the P/W/H derivation functions, reused by the padding side.
REQ-020 No sub-module; one file, counters + FSM + output register.

Verification
REQ-021 Defaults, in_data=0..24 back-to-back, out_ready=1 -> outputs 6,7,8,11,12,13,16,17,18 each one cycle after acceptance; out_last only with 18.
REQ-022 Same stream, out_ready low 3 cycles while out_valid holds 12 -> out_data stays 12, in_ready=0, no loss; remaining order unchanged.
REQ-023 rst_n=0 after pixel 12 accepted, then fresh 0..24 -> out_valid=0 next cycle; new frame yields 6..18 correctly.
REQ-024 kernalSize=1, imageWidth=imageHeight=2, inputs 0..3 -> outputs 0,1,2,3, out_last with 3.
REQ-025 Macro defined, in_last=1 on index 10 -> err=1; following 0..24 frame yields 6..18 correctly, err remains 1.
REQ-026 Two frames back-to-back with random in_valid gaps -> 18 outputs in order, two out_last pulses.
